// File: rtl/fifo_seq_checker.sv
`timescale 1ns/1ps
// Sink that checks the FIFO read-stage beat stream against the START..STOP
// ramp and reports a pass/fail verdict on status outputs and a 4-bit LED pattern.
module fifo_seq_checker #(
  parameter int START     = 0,
  parameter int STOP      = 255,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT   = 1000000,
  parameter int BLINK_DIV = 202400
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [7:0]        err_cnt,
  output logic [DATA_W-1:0] first_err_got,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [3:0]        leds,
  output logic [1:0]        dbg_state
);

  // Handshake: one beat transfers on every cycle rd_valid is high; there is
  // no ready, the checker always accepts, and beats outside ARMED/CHECK are dropped.

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CHECK, S_DONE} state_t;

  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);

  localparam logic [DATA_W-1:0]  START_V    = DATA_W'(START);
  localparam logic [DATA_W-1:0]  STOP_V     = DATA_W'(STOP);
  localparam logic [DATA_W-1:0]  ONE_D      = DATA_W'(1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
  localparam logic [STALL_W-1:0] ONE_S      = STALL_W'(1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [BLINK_W-1:0] ONE_B      = BLINK_W'(1);

  state_t              state;
  state_t              state_nxt;
  logic                start_prev;
  logic                start_pulse;
  logic [DATA_W-1:0]   expected;
  logic [STALL_W-1:0]  stall_cnt;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                blink_on;
  logic                beat;
  logic                mismatch;
  logic                last_beat;
  logic                stall_expire;

  assign beat         = rd_valid && !start_pulse && (state == S_ARMED || state == S_CHECK);
  assign mismatch     = beat && (rd_data != expected);
  assign last_beat    = beat && (expected == STOP_V);
  assign stall_expire = (state == S_CHECK) && !rd_valid && (stall_cnt == STALL_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // A start edge re-arms from any state, so an abort needs no extra arcs.
  always_comb begin
    state_nxt = state;
    if (start_pulse) begin
      state_nxt = S_ARMED;
    end else begin
      case (state)
        S_ARMED: if (beat) state_nxt = last_beat ? S_DONE : S_CHECK;
        S_CHECK: if (last_beat || stall_expire) state_nxt = S_DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy      = (state == S_ARMED) || (state == S_CHECK);
    done      = (state == S_DONE);
    pass      = done && (err_cnt == 8'd0) && !timeout;
    dbg_state = state;
    case (state)
      S_CHECK: leds = expected[DATA_W-1:DATA_W-4];
      S_DONE:  leds = pass ? {4{blink_on}} : {1'b1, timeout, err_cnt[1:0]};
      default: leds = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      start_prev    <= 1'b0;
      start_pulse   <= 1'b0;
      expected      <= '0;
      stall_cnt     <= '0;
      err_cnt       <= 8'd0;
      first_err_got <= '0;
      first_err_exp <= '0;
      timeout       <= 1'b0;
    end else begin
      start_prev  <= start;
      start_pulse <= start & ~start_prev;
      if (start_pulse) begin
        expected      <= START_V;
        stall_cnt     <= '0;
        err_cnt       <= 8'd0;
        first_err_got <= '0;
        first_err_exp <= '0;
        timeout       <= 1'b0;
      end else begin
        if (beat) begin
          // Expected advances even on a mismatch so a dropped beat keeps failing.
          expected  <= expected + ONE_D;
          stall_cnt <= '0;
          if (mismatch) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (err_cnt == 8'd0) begin
              first_err_got <= rd_data;
              first_err_exp <= expected;
            end
          end
        end else if (state == S_CHECK) begin
          stall_cnt <= stall_cnt + ONE_S;
        end
        if (stall_expire) timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      blink_on  <= 1'b0;
      blink_cnt <= '0;
    end else if (state_nxt == S_DONE && state != S_DONE) begin
      blink_on  <= 1'b1;
      blink_cnt <= '0;
    end else if (state == S_DONE) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_on  <= ~blink_on;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + ONE_B;
      end
    end else begin
      blink_on  <= 1'b0;
      blink_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_fifo_seq_checker.sv
`timescale 1ns/1ps
// Bench for fifo_seq_checker: table of stream scenarios, hand-written control
// corners, and randomized streams scored against a verdict model.
module tb_fifo_seq_checker;

  localparam int DATA_W    = 8;
  localparam int START     = 0;
  localparam int STOP      = 255;
  localparam int TIMEOUT   = 100;
  localparam int BLINK_DIV = 8;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              rd_valid = 1'b0;
  logic              busy, done, pass, timeout;
  logic [7:0]        err_cnt;
  logic [DATA_W-1:0] first_err_got, first_err_exp;
  logic [3:0]        leds;
  logic [1:0]        dbg_state;

  fifo_seq_checker #(
    .START(START), .STOP(STOP), .DATA_W(DATA_W),
    .TIMEOUT(TIMEOUT), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt),
    .first_err_got(first_err_got), .first_err_exp(first_err_exp),
    .leds(leds), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cyc = 0;
  int bcyc[$];

  typedef struct {
    string      name;
    int         n_beats;
    int         bad_idx;
    logic [7:0] bad_val;
    int         drop_idx;
    int         max_gap;
    int         exp_err;
    logic [7:0] exp_got;
    logic [7:0] exp_exp;
    bit         exp_to;
    logic [3:0] exp_leds;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic send(input logic [7:0] q[$], input int max_gap);
    bcyc.delete();
    foreach (q[i]) begin
      repeat ($urandom_range(0, max_gap)) tick();
      rd_valid = 1'b1;
      rd_data  = q[i];
      tick();
      bcyc.push_back(cyc);
      rd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < TIMEOUT + 20; i++) begin
      if (done) break;
      tick();
    end
    done_cyc = cyc;
    check({name, "_done_reached"}, 32'(done), 32'd1);
  endtask

  // verdict model: walk the beats against the ramp START, START+1, ...
  function automatic void ref_model(input logic [7:0] q[$], output int errs,
                                    output logic [7:0] got, output logic [7:0] exp,
                                    output bit to);
    errs = 0; got = 8'h00; exp = 8'h00; to = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      int e;
      e = START + i;
      if (int'(q[i]) != e) begin
        if (errs == 0) begin
          got = q[i];
          exp = 8'(e);
        end
        if (errs < 255) errs++;
      end
      if (e == STOP) begin
        to = 1'b0;
        break;
      end
    end
  endfunction

  function automatic logic [3:0] led_model(input int errs, input bit to);
    logic [7:0] ec;
    ec = 8'(errs);
    if (errs == 0 && !to) return 4'hF;
    return {1'b1, to, ec[1:0]};
  endfunction

  // scoreboard for one completed test: verdict, timing and LEDs
  task automatic score(input string name, input int exp_err, input logic [7:0] exp_got,
                       input logic [7:0] exp_exp, input bit exp_to, input logic [3:0] exp_leds);
    int exp_done;
    wait_done(name);
    exp_done = bcyc[$] + (exp_to ? TIMEOUT : 0);
    check({name, "_done_time"}, 32'(done_cyc), 32'(exp_done));
    check({name, "_busy"},      32'(busy), 32'd0);
    check({name, "_err_cnt"},   32'(err_cnt), 32'(exp_err));
    check({name, "_first_got"}, 32'(first_err_got), 32'(exp_got));
    check({name, "_first_exp"}, 32'(first_err_exp), 32'(exp_exp));
    check({name, "_timeout"},   32'(timeout), 32'(exp_to));
    check({name, "_pass"},      32'(pass), 32'(exp_err == 0 && !exp_to));
    check({name, "_leds"},      32'(leds), 32'(exp_leds));
  endtask

  task automatic run_case(input string name, input logic [7:0] q[$], input int max_gap,
                          input int exp_err, input logic [7:0] exp_got, input logic [7:0] exp_exp,
                          input bit exp_to, input logic [3:0] exp_leds);
    arm();
    send(q, max_gap);
    score(name, exp_err, exp_got, exp_exp, exp_to, exp_leds);
  endtask

  task automatic blink_check();
    for (int k = 0; k < 40; k++) begin
      int d;
      tick();
      d = cyc - done_cyc;
      check("blink_leds", 32'(leds), ((d / BLINK_DIV) % 2 == 0) ? 32'hF : 32'h0);
    end
  endtask

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL global_time_limit: got expired, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    logic [7:0] q[$];
    int         errs;
    logic [7:0] mg, me;
    bit         mt;

    vecs[0] = '{"clean",        256,  -1, 8'h00,  -1,  0,   0, 8'h00, 8'h00, 1'b0, 4'hF};
    vecs[1] = '{"gappy",        256,  -1, 8'h00,  -1, 50,   0, 8'h00, 8'h00, 1'b0, 4'hF};
    vecs[2] = '{"corrupt17",    256,  17, 8'h55,  -1,  0,   1, 8'h55, 8'h11, 1'b0, 4'h9};
    vecs[3] = '{"corrupt_last", 256, 255, 8'h00,  -1,  0,   1, 8'h00, 8'hFF, 1'b0, 4'h9};
    vecs[4] = '{"drop100",      256,  -1, 8'h00, 100,  0, 155, 8'h65, 8'h64, 1'b1, 4'hF};
    vecs[5] = '{"stall",         10,  -1, 8'h00,  -1,  0,   0, 8'h00, 8'h00, 1'b1, 4'hC};

    // reset state
    n_rst = 1'b0;
    repeat (3) tick();
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_done",      32'(done), 32'd0);
    check("rst_pass",      32'(pass), 32'd0);
    check("rst_timeout",   32'(timeout), 32'd0);
    check("rst_err_cnt",   32'(err_cnt), 32'd0);
    check("rst_first_got", 32'(first_err_got), 32'd0);
    check("rst_first_exp", 32'(first_err_exp), 32'd0);
    check("rst_leds",      32'(leds), 32'd0);
    check("rst_state",     32'(dbg_state), 32'd0);
    n_rst = 1'b1;
    tick();

    // start edge at edge N shows as busy only after edge N+1
    start = 1'b1;
    tick();
    check("arm_busy_edge_n", 32'(busy), 32'd0);
    start = 1'b0;
    tick();
    check("arm_busy_edge_n1", 32'(busy), 32'd1);

    // start held high arms once; the stall watchdog then ends the test and it stays ended
    start = 1'b1;
    tick();
    tick();
    check("held_busy", 32'(busy), 32'd1);
    q.delete();
    for (int b = 0; b < 10; b++) q.push_back(8'(START + b));
    send(q, 0);
    repeat (1000 - 12) tick();
    check("held_done",    32'(done), 32'd1);
    check("held_timeout", 32'(timeout), 32'd1);
    check("held_err_cnt", 32'(err_cnt), 32'd0);
    start = 1'b0;
    tick();

    // restart at beat 50, with a beat in the same cycle as the restart
    arm();
    q.delete();
    for (int b = 0; b < 50; b++) q.push_back(b == 10 ? 8'hAA : 8'(START + b));
    send(q, 0);
    check("restart_pre_err",  32'(err_cnt), 32'd1);
    check("restart_pre_leds", 32'(leds), 32'h3);
    start    = 1'b1;
    rd_valid = 1'b1;
    rd_data  = 8'd50;
    tick();
    start   = 1'b0;
    rd_data = 8'd51;
    tick();
    rd_valid = 1'b0;
    check("restart_busy",      32'(busy), 32'd1);
    check("restart_err_clear", 32'(err_cnt), 32'd0);
    check("restart_got_clear", 32'(first_err_got), 32'd0);
    check("restart_exp_clear", 32'(first_err_exp), 32'd0);
    q.delete();
    for (int b = 0; b <= STOP - START; b++) q.push_back(8'(START + b));
    send(q, 0);
    score("restart_run", 0, 8'h00, 8'h00, 1'b0, 4'hF);

    // table-driven scenarios
    for (int i = 0; i < 6; i++) begin
      q.delete();
      for (int b = 0; b < vecs[i].n_beats; b++)
        if (b != vecs[i].drop_idx)
          q.push_back(b == vecs[i].bad_idx ? vecs[i].bad_val : 8'(START + b));
      run_case(vecs[i].name, q, vecs[i].max_gap, vecs[i].exp_err, vecs[i].exp_got,
               vecs[i].exp_exp, vecs[i].exp_to, vecs[i].exp_leds);
      if (i == 0) blink_check();
    end

    // randomized streams against the verdict model
    for (int r = 0; r < 5; r++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 200)) : 256;
      q.delete();
      for (int b = 0; b < n; b++) q.push_back(8'(START + b));
      repeat ($urandom_range(0, 3)) q[$urandom_range(0, n - 1)] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) q.delete($urandom_range(0, q.size() - 1));
      ref_model(q, errs, mg, me, mt);
      run_case($sformatf("random%0d", r), q, $urandom_range(0, 8), errs, mg, me, mt,
               led_model(errs, mt));
    end

    // reset in the middle of CHECK
    arm();
    q.delete();
    for (int b = 0; b < 20; b++) q.push_back(b == 5 ? 8'hF0 : 8'(START + b));
    send(q, 0);
    check("midrst_pre_err", 32'(err_cnt), 32'd1);
    n_rst = 1'b0;
    #1;
    check("midrst_busy",  32'(busy), 32'd0);
    check("midrst_err",   32'(err_cnt), 32'd0);
    check("midrst_got",   32'(first_err_got), 32'd0);
    check("midrst_exp",   32'(first_err_exp), 32'd0);
    check("midrst_leds",  32'(leds), 32'd0);
    check("midrst_done",  32'(done), 32'd0);
    tick();
    n_rst = 1'b1;
    repeat (20) tick();
    check("midrst_stay_idle", 32'(dbg_state), 32'd0);
    check("midrst_stay_busy", 32'(busy), 32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_seq_checker.md
# fifo_seq_checker

Self-checking sink placed directly downstream of the FIFO read stage. Consumes the read stage's `rd_data`/`rd_valid` beat stream, checks it against the incrementing pattern the write stage injects (`START`..`STOP`), and counts mismatches, missing beats and stalls. It reports a pass/fail verdict on status outputs and on a 4-bit active-high LED pattern, which the top level inverts onto the board LEDs.

## Interface
- `START`, 0, first expected data value
- `STOP`, 255, last expected data value; `STOP >= START` is required, and equal values give a 1-beat test
- `DATA_W`, 8, data width; `START` and `STOP` must fit in it
- `TIMEOUT`, 1000000, maximum number of consecutive cycles without `rd_valid` while in CHECK
- `BLINK_DIV`, 202400, half-period of the DONE blink, in clock cycles
- `clk`  in  1  single clock, all logic on rising edge
- `n_rst`  in  1  asynchronous, active-low reset
- `start`  in  1  level input, synchronous to `clk`; a rising edge arms or re-arms a test
- `rd_data`  in  DATA_W  beat data from the read stage
- `rd_valid`  in  1  `rd_data` is valid this cycle; one beat per high cycle, no backpressure
- `busy`  out  1  high in ARMED or CHECK
- `done`  out  1  high in DONE
- `pass`  out  1  valid only while `done` is high; 1 = no errors and no timeout
- `timeout`  out  1  DONE was reached by the stall watchdog
- `err_cnt`  out  8  mismatch count, saturates at 255
- `first_err_got`  out  DATA_W  `rd_data` of the first mismatch
- `first_err_exp`  out  DATA_W  expected value at the first mismatch
- `leds`  out  4  active-high status pattern

## Operation
- FSM states:
  - IDLE: `leds`=0000.
  - ARMED: expected value = `START`, counters cleared.
  - CHECK: `leds` = expected[DATA_W-1:DATA_W-4], so progress is visible.
  - DONE: on pass, all four `leds` toggle together every `BLINK_DIV` cycles, starting lit. On fail, `leds` = {1, `timeout`, `err_cnt`[1:0]} steady.
- Transitions:
  - IDLE→ARMED on a `start` rising edge, detected by a registered previous value, so a held-high `start` arms only once.
  - ARMED→CHECK on the first `rd_valid`. That beat is checked in the same cycle.
  - CHECK→DONE when a beat is checked with expected == `STOP`, or when the stall counter reaches `TIMEOUT`.
  - DONE→ARMED on a new `start` rising edge.
  - A `start` edge in ARMED or CHECK aborts the test and re-enters ARMED with all counters and capture registers cleared.
- Per checked beat:
  - If `rd_data` != expected: `err_cnt` increments (saturating), and `first_err_*` is captured only when `err_cnt` was 0.
  - Expected then increments by 1 regardless of match, so a dropped beat shows as one mismatch per following beat.
- Stall counter:
  - Clears on every `rd_valid` and on entering CHECK.
  - Increments each cycle in CHECK without `rd_valid`.
  - Sized ceil(log2(`TIMEOUT`+1)) bits.
  - No watchdog runs in ARMED; it waits indefinitely.
- `rd_valid` in IDLE or DONE is ignored.
- `pass` = (`err_cnt`==0) && !`timeout`.

## Timing
- Reset (async assert, sync release): state IDLE, and every output is 0, including `leds`, `err_cnt` and `first_err_*`. The blink phase and edge-detect register are also 0.
- All outputs are registered. A beat at edge N is reflected in `err_cnt`/`first_err_*` after edge N; `leds` in CHECK follow expected with the same one-edge latency.
- The last beat (expected == `STOP`) is sampled at edge N, and `done`=1 and `busy`=0 from edge N on. The beat is counted in the final verdict.
- A `start` rising edge sampled at edge N makes `busy`=1 after edge N+1 (edge-detect register plus state register).
- Timeout: after the last beat at edge N, with no further `rd_valid`, DONE is entered at edge N+`TIMEOUT`, with `timeout`=1 and `pass`=0.
- `rd_valid` and a `start` edge in the same cycle: the restart wins and the beat is dropped.
- Reset mid-CHECK: immediate return to IDLE. A test only restarts on a fresh `start` edge.

## Test plan
- Clean run: pulse `start`, then feed 0..255 with `rd_valid` every cycle → `done`=1 one edge after beat 255, `pass`=1, `err_cnt`=0, and `leds` blink with period 2×`BLINK_DIV`.
- Gappy stream: 0..255 with random 0–50 cycle gaps (`TIMEOUT`=100) → `pass`=1, `timeout`=0.
- Corruption: beat 17 sent as 0x55 → `err_cnt`=1, `first_err_got`=0x55, `first_err_exp`=0x11, `pass`=0, `leds`=1001.
- Dropped beat: stream 0..255 with 100 omitted (`TIMEOUT`=100) → mismatches on 101..255 give `err_cnt`=155 and `first_err_exp`=100. DONE is reached via the stall watchdog `TIMEOUT` cycles after beat 255, with `timeout`=1.
- Stall: send 0..9, then hold `rd_valid` low (`TIMEOUT`=100) → DONE exactly 100 cycles after beat 9, `timeout`=1, `leds`=1100.
- Control corners:
  - `start` held high for 1000 cycles arms only once.
  - A `start` re-edge at beat 50 restarts with expected=0.
  - `n_rst` pulsed mid-CHECK → all outputs 0 immediately, and the block stays in IDLE until a new edge.
